icache_ctrl_nway: RTL and testbench
===================================

// Module: icache_ctrl_nway
// PURPOSE
//  Control FSM for an N-way set-associative ICache with multi-beat line refill.
//  Sits between the IF stage and the AXI-side read bridge, above the tag/data RAMs.
//  Adds to the 2-way single-word controller: parametrised ways and line length,
//  burst refill buffer, round-robin replacement, uncached fetch, and index-invalidate (CACOP).
// PARAMETERS
//  WAYS        2   number of ways; power of 2, >=2
//  LINE_WORDS  4   32-bit words per line = refill beats; power of 2, >=1
//  WORD        32  data/address width (from `WORD)
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 synchronous reset, active-high
//  pipeline_valid in   1                 fetch request
//  addr           in   WORD              fetch address
//  uncached       in   1                 fetch bypasses cache (sampled with addr)
//  hit            in   WAYS              per-way tag match, valid in CMP
//  inv_valid      in   1                 CACOP index-invalidate request (index from addr)
//  mem_addr_ok    in   1                 bridge accepted read request
//  mem_ret_valid  in   1                 return beat valid
//  mem_ret_last   in   1                 final return beat
//  mem_ret_data   in   WORD              return beat data
//  rbuf_we        out  1                 latch request (addr/uncached) into request buffer
//  pipeline_ready out  1                 fetch complete (1-cycle pulse)
//  select_way     out  $clog2(WAYS)      way supplying hit data
//  is_data_from_mem out 1                resp_data valid instead of cache data
//  resp_data      out  WORD              word from refill buffer at latched offset
//  mem_rd_req     out  1                 read request to bridge
//  mem_rd_type    out  1                 0 = single word, 1 = full line
//  mem_rd_addr    out  WORD              line-aligned (cached) or exact (uncached)
//  cache_we       out  WAYS              one-hot line write into replacement way
//  refill_line    out  LINE_WORDS*WORD   line data to data RAM, word 0 in LSBs
//  inv_we         out  WAYS              clear valid bit of every way at index
//  inv_ready      out  1                 invalidate complete (1-cycle pulse)
// BEHAVIOUR
//  Reset: state IDLE; every output 0; repl_ptr 0; beat_cnt 0; refill buffer 0; latched addr 0.
//  States: IDLE, LOOKUP, CMP, MISS, REFILL, WRITE, INVAL.
//  IDLE: inv_valid -> INVAL (wins over pipeline_valid same cycle). Else pipeline_valid ->
//   rbuf_we=1, latch addr/uncached, -> LOOKUP. Requests outside IDLE are ignored, not queued.
//  LOOKUP: one cycle of RAM read latency -> CMP.
//  CMP: uncached -> MISS. |hit -> select_way = index of lowest set hit bit, pipeline_ready=1,
//   -> IDLE (hit latency: ready 2 cycles after accept). No hit -> MISS.
//  MISS: mem_rd_req=1 held with stable mem_rd_addr/mem_rd_type until mem_addr_ok; then
//   beat_cnt=0, -> REFILL. Cached: addr with low log2(LINE_WORDS*4) bits zeroed, type 1.
//  REFILL: each mem_ret_valid writes buffer[beat_cnt], beat_cnt++. Beat with mem_ret_last, or
//   beat_cnt==LINE_WORDS-1, -> WRITE. Early last: unfilled words keep old contents.
//   Beats beyond LINE_WORDS are impossible by construction (exit on final beat).
//  WRITE (1 cycle): pipeline_ready=1, is_data_from_mem=1, resp_data = buffer[addr word offset]
//   (uncached: buffer[0]). Cached: cache_we = 1<<repl_ptr, refill_line = buffer,
//   repl_ptr++ wrapping WAYS-1 -> 0. Uncached: cache_we=0, repl_ptr unchanged. -> IDLE.
//  INVAL (1 cycle): inv_we all ones, inv_ready=1, -> IDLE.
//  mem_ret_valid outside REFILL is ignored. rst in any state: -> IDLE next edge, no cache_we,
//   late bridge beats after reset ignored. All outputs except latched regs are Moore/
//   combinational from state, no glitch requirements beyond single-clock timing.
// STRUCTURE
//  `WORD, `CACHE_WAY and LINE_WORDS default in CPU_Parameter.vh; state encodings local params.
//  Sub-module icache_refill_buffer: LINE_WORDS x WORD regs, beat counter, write/clear, word
//  select; FSM owns state, request buffer, repl_ptr.
// TESTING
//  Hit way 1 (WAYS=4, hit=4'b0010): accept t0 -> pipeline_ready t2, select_way=1, no mem_rd_req.
//  Miss 0x1C00_0034, LINE_WORDS=4: mem_rd_addr=0x1C00_0030 type 1; beats A,B,C,D(last) ->
//   WRITE: cache_we=1<<ptr, refill_line={D,C,B,A}, resp_data=B, ptr advances.
//  Four consecutive misses WAYS=4 -> cache_we 0001,0010,0100,1000, fifth 0001.
//  Uncached 0x1FD0_0004: type 0, exact addr, one beat 0xDEAD_BEEF -> resp_data, cache_we=0.
//  inv_valid & pipeline_valid same cycle in IDLE -> INVAL first, inv_we all ones; fetch dropped.
//  rst during REFILL after 2 beats -> IDLE, no cache_we; stray beats ignored; next fetch normal.

Source files
------------

// File: rtl/icache_ctrl_nway_pkg.sv
// Shared constants for the N-way ICache controller: FSM encodings and a width helper.
package icache_ctrl_nway_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CMP    = 3'd2;
    localparam logic [2:0] S_MISS   = 3'd3;
    localparam logic [2:0] S_REFILL = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_INVAL  = 3'd6;

    // Index width that never collapses to zero bits (single-word lines still need a port).
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_buffer.sv
// Line assembly buffer: collects refill beats in order and exposes the whole line
// plus one selected word for the fetch response.
module icache_refill_buffer
    import icache_ctrl_nway_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int WORD       = 32,
    localparam int CW        = clog2_min1(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         we,
    input  logic [WORD-1:0]              wdata,
    input  logic [CW-1:0]                rd_off,
    output logic [LINE_WORDS*WORD-1:0]   line,
    output logic                         last_slot,
    output logic [WORD-1:0]              rd_word
);

    logic [LINE_WORDS-1:0][WORD-1:0] words_q, words_d;
    logic [CW-1:0]                   cnt_q, cnt_d;

    // Beat write at the current slot; clearing only rewinds the counter so an early
    // last beat leaves the tail words as they were.
    always_comb begin
        words_d = words_q;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (we) begin
            words_d[cnt_q] = wdata;
            cnt_d          = cnt_q + 1'b1;
        end
    end

    // Buffer and beat counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            cnt_q   <= '0;
        end else begin
            words_q <= words_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line      = words_q;
    assign last_slot = (cnt_q == CW'(LINE_WORDS - 1));
    assign rd_word   = words_q[rd_off];

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative ICache control FSM: lookup/compare, line or single-word
// refill through the read bridge, round-robin fill way, and index invalidate.
module icache_ctrl_nway
    import icache_ctrl_nway_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int WORD       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipeline_valid,
    input  logic [WORD-1:0]              addr,
    input  logic                         uncached,
    input  logic [WAYS-1:0]              hit,
    input  logic                         inv_valid,
    input  logic                         mem_addr_ok,
    input  logic                         mem_ret_valid,
    input  logic                         mem_ret_last,
    input  logic [WORD-1:0]              mem_ret_data,
    output logic                         rbuf_we,
    output logic                         pipeline_ready,
    output logic [$clog2(WAYS)-1:0]      select_way,
    output logic                         is_data_from_mem,
    output logic [WORD-1:0]              resp_data,
    output logic                         mem_rd_req,
    output logic                         mem_rd_type,
    output logic [WORD-1:0]              mem_rd_addr,
    output logic [WAYS-1:0]              cache_we,
    output logic [LINE_WORDS*WORD-1:0]   refill_line,
    output logic [WAYS-1:0]              inv_we,
    output logic                         inv_ready
);

    localparam int PW = $clog2(WAYS);
    localparam int CW = clog2_min1(LINE_WORDS);
    localparam logic [WORD-1:0] LINE_MASK = WORD'(LINE_WORDS * 4 - 1);

    logic [2:0]      state_q, state_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic            unc_q, unc_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic                       rb_clr, rb_we, rb_last_slot;
    logic [CW-1:0]              rb_off;
    logic [WORD-1:0]            rb_word;
    logic [LINE_WORDS*WORD-1:0] rb_line;
    logic [PW-1:0]              hit_idx;

    icache_refill_buffer #(.LINE_WORDS(LINE_WORDS), .WORD(WORD)) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (rb_clr),
        .we        (rb_we),
        .wdata     (mem_ret_data),
        .rd_off    (rb_off),
        .line      (rb_line),
        .last_slot (rb_last_slot),
        .rd_word   (rb_word)
    );

    // Uncached fetches always return the single beat held in word 0.
    assign rb_off = (unc_q || LINE_WORDS == 1) ? '0 : addr_q[2 +: CW];

    // Lowest-numbered matching way wins when several tags match.
    always_comb begin
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (hit[i]) hit_idx = PW'(i);
    end

    // Next state and outputs; everything is forced quiet while reset is held so a
    // reset landing in WRITE can never commit a line.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        unc_d            = unc_q;
        ptr_d            = ptr_q;
        rb_clr           = 1'b0;
        rb_we            = 1'b0;
        rbuf_we          = 1'b0;
        pipeline_ready   = 1'b0;
        select_way       = '0;
        is_data_from_mem = 1'b0;
        resp_data        = '0;
        mem_rd_req       = 1'b0;
        mem_rd_type      = 1'b0;
        mem_rd_addr      = '0;
        cache_we         = '0;
        refill_line      = '0;
        inv_we           = '0;
        inv_ready        = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (inv_valid) begin
                        state_d = S_INVAL;
                    end else if (pipeline_valid) begin
                        rbuf_we = 1'b1;
                        addr_d  = addr;
                        unc_d   = uncached;
                        state_d = S_LOOKUP;
                    end
                end
                S_LOOKUP: state_d = S_CMP;
                S_CMP: begin
                    if (!unc_q && |hit) begin
                        pipeline_ready = 1'b1;
                        select_way     = hit_idx;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_MISS;
                    end
                end
                S_MISS: begin
                    mem_rd_req  = 1'b1;
                    mem_rd_type = ~unc_q;
                    mem_rd_addr = unc_q ? addr_q : (addr_q & ~LINE_MASK);
                    if (mem_addr_ok) begin
                        rb_clr  = 1'b1;
                        state_d = S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ret_valid) begin
                        rb_we = 1'b1;
                        if (mem_ret_last || rb_last_slot) state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    pipeline_ready   = 1'b1;
                    is_data_from_mem = 1'b1;
                    resp_data        = rb_word;
                    if (!unc_q) begin
                        cache_we    = WAYS'(1) << ptr_q;
                        refill_line = rb_line;
                        ptr_d       = ptr_q + 1'b1;
                    end
                    state_d = S_IDLE;
                end
                S_INVAL: begin
                    inv_we    = '1;
                    inv_ready = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state, request buffer and replacement pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            unc_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            unc_q   <= unc_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed bench for icache_ctrl_nway (WAYS=4, LINE_WORDS=4): a transaction model
// sets the expected outputs for every cycle and one compare process checks them.
module tb_icache_ctrl_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         pipeline_valid, uncached, inv_valid;
    logic [31:0]  addr;
    logic [3:0]   hit;
    logic         mem_addr_ok, mem_ret_valid, mem_ret_last;
    logic [31:0]  mem_ret_data;
    logic         rbuf_we, pipeline_ready, is_data_from_mem, mem_rd_req, mem_rd_type, inv_ready;
    logic [1:0]   select_way;
    logic [31:0]  resp_data, mem_rd_addr;
    logic [3:0]   cache_we, inv_we;
    logic [127:0] refill_line;

    // expectations for the current cycle
    logic         e_rbuf, e_rdy, e_mem, e_req, e_type, e_inv_rdy;
    logic [1:0]   e_sel;
    logic [31:0]  e_resp, e_raddr;
    logic [3:0]   e_cwe, e_inv_we;
    logic [127:0] e_line;

    // model state: line buffer contents and fill pointer
    logic [31:0]  mbuf [4];
    int           mptr;
    int           checks = 0;
    int           errors = 0;
    bit           run = 1'b0;

    icache_ctrl_nway #(.WAYS(4), .LINE_WORDS(4), .WORD(32)) dut (
        .clk(clk), .rst(rst), .pipeline_valid(pipeline_valid), .addr(addr),
        .uncached(uncached), .hit(hit), .inv_valid(inv_valid),
        .mem_addr_ok(mem_addr_ok), .mem_ret_valid(mem_ret_valid),
        .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
        .rbuf_we(rbuf_we), .pipeline_ready(pipeline_ready), .select_way(select_way),
        .is_data_from_mem(is_data_from_mem), .resp_data(resp_data),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .cache_we(cache_we), .refill_line(refill_line), .inv_we(inv_we), .inv_ready(inv_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (run) begin
            chk("rbuf_we", 128'(rbuf_we), 128'(e_rbuf));
            chk("pipeline_ready", 128'(pipeline_ready), 128'(e_rdy));
            chk("select_way", 128'(select_way), 128'(e_sel));
            chk("is_data_from_mem", 128'(is_data_from_mem), 128'(e_mem));
            chk("resp_data", 128'(resp_data), 128'(e_resp));
            chk("mem_rd_req", 128'(mem_rd_req), 128'(e_req));
            chk("mem_rd_type", 128'(mem_rd_type), 128'(e_type));
            chk("mem_rd_addr", 128'(mem_rd_addr), 128'(e_raddr));
            chk("cache_we", 128'(cache_we), 128'(e_cwe));
            chk("refill_line", refill_line, e_line);
            chk("inv_we", 128'(inv_we), 128'(e_inv_we));
            chk("inv_ready", 128'(inv_ready), 128'(e_inv_rdy));
        end
    end

    // Advance one cycle; pulse inputs and expectations return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        pipeline_valid = 0; inv_valid = 0; hit = 0; mem_addr_ok = 0;
        mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
        e_rbuf = 0; e_rdy = 0; e_sel = 0; e_mem = 0; e_resp = 0; e_req = 0;
        e_type = 0; e_raddr = 0; e_cwe = 0; e_line = 0; e_inv_we = 0; e_inv_rdy = 0;
    endtask

    task automatic hit_fetch(input logic [31:0] a, input logic [3:0] h, input logic [1:0] sel);
        step(); pipeline_valid = 1; addr = a; uncached = 0; e_rbuf = 1;
        step();
        step(); hit = h; e_rdy = 1; e_sel = sel;
    endtask

    // Full miss transaction. ea is the hand-computed bridge address. nb beats are
    // returned (last flagged on the final one); rst_after >= 0 aborts with a reset.
    task automatic miss(input logic [31:0] a, input bit unc, input logic [31:0] ea,
                        input int nb, input int okd, input logic [31:0] base, input int rst_after);
        step(); pipeline_valid = 1; addr = a; uncached = unc; e_rbuf = 1;
        step();
        step(); hit = unc ? 4'b0001 : 4'b0000;
        for (int d = 0; d <= okd; d++) begin
            step(); e_req = 1; e_type = !unc; e_raddr = ea; mem_addr_ok = (d == okd);
        end
        for (int i = 0; i < nb; i++) begin
            if (i == rst_after) begin
                step(); rst = 1;
                step(); rst = 0;
                for (int k = 0; k < 4; k++) mbuf[k] = 0;
                mptr = 0;
                return;
            end
            if (i == 1) step();
            step();
            mem_ret_valid = 1; mem_ret_data = base + i; mem_ret_last = (i == nb - 1);
            pipeline_valid = (rst_after >= 0);
            addr = 32'h1C00_0F00;
            mbuf[i] = base + i;
        end
        step();
        e_rdy = 1; e_mem = 1;
        e_resp = unc ? mbuf[0] : mbuf[a[3:2]];
        if (!unc) begin
            e_cwe  = 4'(1 << mptr);
            e_line = {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
            mptr   = (mptr + 1) % 4;
        end
    endtask

    initial begin
        rst = 1; addr = 0; uncached = 0;
        for (int k = 0; k < 4; k++) mbuf[k] = 0;
        mptr = 0;
        step(); rst = 1;
        run = 1;
        step(); rst = 1;
        step(); rst = 0;

        hit_fetch(32'h1C00_0010, 4'b0010, 2'd1);
        hit_fetch(32'h1C00_0020, 4'b0110, 2'd1);
        hit_fetch(32'h1C00_0030, 4'b1000, 2'd3);

        miss(32'h1C00_0034, 0, 32'h1C00_0030, 4, 2, 32'hA000_0000, -1);
        @(negedge clk); #1;
        chk("lit_line1", refill_line, 128'hA0000003_A0000002_A0000001_A0000000);
        chk("lit_resp1", 128'(resp_data), 128'h0000_0000_0000_0000_0000_0000_A000_0001);
        chk("lit_we1", 128'(cache_we), 128'd1);

        miss(32'h1C00_0100, 0, 32'h1C00_0100, 4, 0, 32'hB000_0000, -1);
        miss(32'h1C00_020C, 0, 32'h1C00_0200, 4, 1, 32'hC000_0000, -1);
        miss(32'h1C00_0308, 0, 32'h1C00_0300, 2, 0, 32'hE000_0000, -1);
        @(negedge clk); #1;
        chk("lit_we4", 128'(cache_we), 128'd8);
        chk("lit_early_last", refill_line, 128'hC0000003_C0000002_E0000001_E0000000);
        chk("lit_resp4", 128'(resp_data), 128'hC000_0002);

        miss(32'h1C00_0404, 0, 32'h1C00_0400, 4, 0, 32'hF000_0000, -1);
        @(negedge clk); #1;
        chk("lit_we5_wrap", 128'(cache_we), 128'd1);

        miss(32'h1FD0_0004, 1, 32'h1FD0_0004, 1, 1, 32'hDEAD_BEEF, -1);
        @(negedge clk); #1;
        chk("lit_unc_resp", 128'(resp_data), 128'hDEAD_BEEF);
        chk("lit_unc_we", 128'(cache_we), 128'd0);

        miss(32'h1C00_0500, 0, 32'h1C00_0500, 4, 0, 32'h5000_0000, -1);
        @(negedge clk); #1;
        chk("lit_we_after_unc", 128'(cache_we), 128'd2);

        // invalidate wins over a same-cycle fetch, which is dropped
        step(); inv_valid = 1; pipeline_valid = 1; addr = 32'h1C00_0700;
        step(); e_inv_we = 4'hF; e_inv_rdy = 1;
        step();
        step();
        step();

        // reset in the middle of a refill, then stray beats, then a normal fetch
        miss(32'h1C00_0600, 0, 32'h1C00_0600, 4, 0, 32'h7000_0000, 2);
        step(); mem_ret_valid = 1; mem_ret_data = 32'h1234_5678;
        step(); mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = 32'h8765_4321;
        step();
        miss(32'h1C00_0208, 0, 32'h1C00_0200, 1, 0, 32'h8000_0000, -1);
        @(negedge clk); #1;
        chk("lit_post_rst_line", refill_line, 128'h00000000_00000000_00000000_80000000);
        chk("lit_post_rst_we", 128'(cache_we), 128'd1);
        chk("lit_post_rst_resp", 128'(resp_data), 128'd0);
        step();
        step();

        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
